data_ram_responder: RTL and testbench

Memory-side responder for the data-RAM test path. It accepts word requests from an initiator over a valid/ready request channel with per-byte write enables. After a programmable number of wait states, it returns a response over a valid/ready response channel. A second, read-only test port gives a continuous debug view of any word. It replaces the bare dual-port RAM instance when the initiator must tolerate variable memory latency.

---
 rtl/data_ram_responder_if.sv | 21 ++
 rtl/data_ram_responder.sv | 129 ++++++++++++
 tb/tb_data_ram_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_responder_if.sv
// Request/response channel between a memory initiator (master) and the data-RAM responder (slave).
interface data_ram_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_wen, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/data_ram_responder.sv
// Word RAM behind a valid/ready request/response channel with programmable wait states,
// byte-enable writes and a registered read-only debug port.
module data_ram_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   data_ram_responder_if.slave  bus,
   input  logic [31:0]          test_addr,
   output logic [31:0]          test_data
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [3:0]          r_cnt;
   logic [3:0]          r_wen;
   logic [ADDR_W-1:0]   r_word;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic [31:0]         r_test_data;
   logic [31:0]         r_mem [DEPTH];

   logic                w_accept;
   logic                w_access;
   logic                w_req_ready;
   logic                w_resp_valid;
   logic [3:0]          w_wen;
   logic [ADDR_W-1:0]   w_word;
   logic [31:0]         w_wdata;
   logic [31:0]         w_old;
   logic [31:0]         w_merged;
   logic                w_unused;

   // Only the word-index bits of either address participate; the rest alias.
   assign w_unused = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0],
                       test_addr[31:ADDR_W+2], test_addr[1:0]};

   assign w_accept = (r_state == S_IDLE) && bus.req_valid;
   assign w_access = (WAIT_CYCLES == 0) ? w_accept
                                        : ((r_state == S_WAIT) && (r_cnt == 4'd1));

   // With no wait states the access happens on the acceptance edge, before the latches load.
   assign w_wen   = (WAIT_CYCLES == 0) ? bus.req_wen                : r_wen;
   assign w_word  = (WAIT_CYCLES == 0) ? bus.req_addr[ADDR_W+1:2]   : r_word;
   assign w_wdata = (WAIT_CYCLES == 0) ? bus.req_wdata              : r_wdata;

   assign w_old = r_mem[w_word];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte
         assign w_merged[gi*8 +: 8] = w_wen[gi] ? w_wdata[gi*8 +: 8] : w_old[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (r_cnt == 4'd1) w_state_next = S_RESP;
         S_RESP:  if (bus.resp_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         S_IDLE:  w_req_ready  = 1'b1;
         S_RESP:  w_resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_rdata = r_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= 4'd0;
         r_wen   <= 4'd0;
         r_word  <= '0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         if (w_accept) begin
            r_wen   <= bus.req_wen;
            r_word  <= bus.req_addr[ADDR_W+1:2];
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'(WAIT_CYCLES);
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access) begin
            r_rdata <= w_merged;
         end
      end
   end

   // Array has no reset; a reset during WAIT simply never reaches the access edge.
   always_ff @(posedge clk) begin
      if (w_access && (|w_wen)) begin
         r_mem[w_word] <= w_merged;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_test_data <= 32'd0;
      end else begin
         r_test_data <= r_mem[test_addr[ADDR_W+1:2]];
      end
   end

   assign test_data = r_test_data;
endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench: three responders (2, 0 and 4 wait states) exercised by directed vectors.
module tb_data_ram_responder;
   logic        clk;
   logic        resetn;
   logic [2:0]  drv_valid;
   logic [2:0]  drv_rready;
   logic [3:0]  drv_wen   [3];
   logic [31:0] drv_addr  [3];
   logic [31:0] drv_wdata [3];
   logic [31:0] drv_taddr [3];
   logic [2:0]  mon_req_ready;
   logic [2:0]  mon_resp_valid;
   logic [31:0] mon_rdata [3];
   logic [31:0] mon_tdata [3];

   typedef struct {
      int          idx;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int hs_cyc  [3];
   bit pending [3];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int W = (gi == 0) ? 2 : ((gi == 1) ? 0 : 4);
         data_ram_responder_if bus ();
         assign bus.req_valid      = drv_valid[gi];
         assign bus.req_wen        = drv_wen[gi];
         assign bus.req_addr       = drv_addr[gi];
         assign bus.req_wdata      = drv_wdata[gi];
         assign bus.resp_ready     = drv_rready[gi];
         assign mon_req_ready[gi]  = bus.req_ready;
         assign mon_resp_valid[gi] = bus.resp_valid;
         assign mon_rdata[gi]      = bus.resp_rdata;
         data_ram_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .bus       (bus),
            .test_addr (drv_taddr[gi]),
            .test_data (mon_tdata[gi])
         );
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int wait_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 4);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out waiting on DUT", nm);
   endtask

   task automatic push(input int i, input logic [31:0] d);
      exp_t e;
      e.idx  = i;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Offers one request; returns just after the accepting edge with valid dropped.
   task automatic issue(input int i, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
      bit ok = 0;
      @(posedge clk);
      #1;
      drv_valid[i] = 1'b1;
      drv_wen[i]   = wen;
      drv_addr[i]  = addr;
      drv_wdata[i] = wdata;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (mon_req_ready[i]) ok = 1;
      end
      if (!ok) timeout("req_accept");
      @(posedge clk);
      #1;
      drv_valid[i] = 1'b0;
   endtask

   task automatic wait_valid(input int i);
      bit ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (mon_resp_valid[i]) ok = 1;
      end
      if (!ok) timeout("resp_valid");
   endtask

   task automatic wait_resp(input int i);
      bit ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (mon_resp_valid[i] && drv_rready[i]) ok = 1;
      end
      if (!ok) timeout("resp_handshake");
      @(posedge clk);
      #1;
   endtask

   // Monitor: latency from request handshake and scoreboard compare on response handshake.
   always @(negedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         if (!resetn) begin
            pending[i] = 0;
         end else begin
            if (drv_valid[i] && mon_req_ready[i]) begin
               hs_cyc[i]  = cyc;
               pending[i] = 1;
            end
            if (mon_resp_valid[i] && pending[i]) begin
               chk("latency", 32'(cyc - hs_cyc[i]), 32'(wait_of(i) + 1));
               pending[i] = 0;
            end
            if (mon_resp_valid[i] && drv_rready[i]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_resp: dut%0d rdata %h with no response expected",
                           i, mon_rdata[i]);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("resp_dut", 32'(i), 32'(e.idx));
                  chk("resp_rdata", mon_rdata[i], e.data);
                  $display("txn dut%0d (wait=%0d) rdata=%h expected=%h", i, wait_of(i),
                           mon_rdata[i], e.data);
               end
            end
         end
      end
   end

   initial begin
      bit any_valid;
      resetn     = 1'b1;
      drv_valid  = 3'b000;
      drv_rready = 3'b111;
      for (int i = 0; i < 3; i++) begin
         drv_wen[i]   = 4'h0;
         drv_addr[i]  = 32'h0;
         drv_wdata[i] = 32'h0;
         drv_taddr[i] = 32'h0;
      end
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_req_ready",  32'(mon_req_ready[0]),  32'd1);
      chk("rst_resp_valid", 32'(mon_resp_valid[0]), 32'd0);
      chk("rst_rdata",      mon_rdata[0],           32'h0);
      chk("rst_test_data",  mon_tdata[0],           32'h0);
      @(posedge clk);
      #3 resetn = 1'b1;

      // Full write then read, 2 wait states
      push(0, 32'h12345678);
      issue(0, 4'hF, 32'h10, 32'h12345678);
      wait_resp(0);
      push(0, 32'h12345678);
      issue(0, 4'h0, 32'h10, 32'h0);
      wait_resp(0);

      // Byte merge with read-first debug port
      drv_taddr[0]  = 32'h10;
      drv_rready[0] = 1'b0;
      push(0, 32'h12BB56DD);
      issue(0, 4'b0101, 32'h10, 32'hAABBCCDD);
      wait_valid(0);
      chk("tport_read_first", mon_tdata[0], 32'h12345678);
      @(negedge clk);
      chk("tport_new", mon_tdata[0], 32'h12BB56DD);
      @(posedge clk);
      #1 drv_rready[0] = 1'b1;
      wait_resp(0);

      // Backpressure with a second request offered continuously
      drv_rready[0] = 1'b0;
      push(0, 32'h12BB56DD);
      issue(0, 4'h0, 32'h10, 32'h0);
      drv_valid[0] = 1'b1;
      drv_wen[0]   = 4'hF;
      drv_addr[0]  = 32'h14;
      drv_wdata[0] = 32'h0BADBEEF;
      push(0, 32'h0BADBEEF);
      wait_valid(0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_resp_valid", 32'(mon_resp_valid[0]), 32'd1);
         chk("bp_rdata",      mon_rdata[0],           32'h12BB56DD);
         chk("bp_req_ready",  32'(mon_req_ready[0]),  32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 drv_rready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_accept", 32'(mon_req_ready[0]), 32'd1);
      @(posedge clk);
      #1 drv_valid[0] = 1'b0;
      wait_resp(0);

      // Asynchronous reset while a response is pending; the response is dropped
      drv_rready[0] = 1'b0;
      issue(0, 4'h0, 32'h14, 32'h0);
      wait_valid(0);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      chk("arst_req_ready",  32'(mon_req_ready[0]),  32'd1);
      chk("arst_resp_valid", 32'(mon_resp_valid[0]), 32'd0);
      chk("arst_rdata",      mon_rdata[0],           32'h0);
      chk("arst_test_data",  mon_tdata[0],           32'h0);
      @(negedge clk);
      #2 resetn = 1'b1;
      @(posedge clk);
      #1 drv_rready[0] = 1'b1;
      push(0, 32'h0BADBEEF);
      issue(0, 4'h0, 32'h14, 32'h0);
      wait_resp(0);

      // Aliasing with zero wait states
      push(1, 32'hCAFEF00D);
      issue(1, 4'hF, 32'h400, 32'hCAFEF00D);
      wait_resp(1);
      push(1, 32'hCAFEF00D);
      issue(1, 4'h0, 32'h000, 32'h0);
      wait_resp(1);
      push(1, 32'hCAFEF00D);
      issue(1, 4'h0, 32'h403, 32'h0);
      wait_resp(1);

      // Reset during WAIT discards the pending write (4 wait states)
      push(2, 32'h0);
      issue(2, 4'hF, 32'h20, 32'h0);
      wait_resp(2);
      issue(2, 4'hF, 32'h20, 32'hFFFFFFFF);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      chk("wait_rst_req_ready", 32'(mon_req_ready[2]), 32'd1);
      @(negedge clk);
      #2 resetn = 1'b1;
      any_valid = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (mon_resp_valid[2]) any_valid = 1;
      end
      chk("abort_no_resp", 32'(any_valid), 32'd0);
      push(2, 32'h0);
      issue(2, 4'h0, 32'h20, 32'h0);
      wait_resp(2);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
